save_wr_engine: RTL and testbench

- Execution stage directly downstream of the save-instruction parser.
- On the parser's `start` pulse, captures the decoded write registers and reads the selected on-chip bank line by line.
- Streams each line to DDR as one write burst (command, data, response).
- Returns a single-cycle `wr_done` to the parser after the final burst response.

---
 rtl/save_wr_engine_pkg.sv | 22 ++
 rtl/save_rd_fifo.sv | 57 +++++
 rtl/save_wr_engine.sv | 216 +++++++++++++++++++++
 tb/tb_save_wr_engine.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/save_wr_engine_pkg.sv
// Shared types and default widths for the save path (parser and write engine).
// FSM encoding, AXI-style response codes and the bus widths both stages agree on.
package save_wr_engine_pkg;

    localparam int BID_W       = 6;
    localparam int ADDR_W      = 12;
    localparam int OFFSET_W    = 4;
    localparam int LINE_SIZE_W = 12;
    localparam int ALL_SIZE_W  = 16;
    localparam int DDR_ADDR_W  = 32;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/save_rd_fifo.sv
// Synchronous read-data buffer between the bank read port and the DDR write channel.
// Depth need not be a power of two; pointers wrap explicitly.
module save_rd_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_wdata,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_rdata,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && (r_cnt != CW'(DEPTH));
    assign w_pop   = i_pop && (r_cnt != '0);
    assign o_rdata = r_mem[r_rp];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= nxt(r_wp);
            if (w_pop)  r_rp <= nxt(r_rp);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/save_wr_engine.sv
// Save execution stage: reads bank lines and writes each as one DDR burst.
// Define SAVE_WR_RESP_CHK_EN to add the sticky wr_err response-error flag.
module save_wr_engine #(
    parameter int BID_W       = save_wr_engine_pkg::BID_W,
    parameter int ADDR_W      = save_wr_engine_pkg::ADDR_W,
    parameter int OFFSET_W    = save_wr_engine_pkg::OFFSET_W,
    parameter int LINE_SIZE_W = save_wr_engine_pkg::LINE_SIZE_W,
    parameter int ALL_SIZE_W  = save_wr_engine_pkg::ALL_SIZE_W,
    parameter int DDR_ADDR_W  = save_wr_engine_pkg::DDR_ADDR_W,
    parameter int DATA_W      = 128,
    parameter int RD_LAT      = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   zero_ddr_step,
    input  logic [BID_W-1:0]       cfg_bank_id,
    input  logic [ADDR_W-1:0]      cfg_bank_addr,
    input  logic [ADDR_W-1:0]      cfg_bank_step,
    input  logic [OFFSET_W-1:0]    cfg_bank_offset,
    input  logic [LINE_SIZE_W-1:0] cfg_line_size,
    input  logic [ALL_SIZE_W-1:0]  cfg_total_size,
    input  logic [ALL_SIZE_W-1:0]  cfg_ddr_step,
    input  logic [DDR_ADDR_W-1:0]  cfg_ddr_addr,
    output logic                   bank_rd_en,
    output logic [BID_W-1:0]       bank_rd_id,
    output logic [ADDR_W-1:0]      bank_rd_addr,
    output logic [OFFSET_W-1:0]    bank_rd_lane,
    input  logic [DATA_W-1:0]      bank_rd_data,
    output logic                   aw_valid,
    input  logic                   aw_ready,
    output logic [DDR_ADDR_W-1:0]  aw_addr,
    output logic [LINE_SIZE_W-1:0] aw_len,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [DATA_W-1:0]      w_data,
    output logic                   w_last,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [1:0]             b_resp,
    output logic                   busy,
    output logic                   wr_done
`ifdef SAVE_WR_RESP_CHK_EN
    ,
    output logic                   wr_err
`endif
);

    import save_wr_engine_pkg::*;

    localparam int BPW = DATA_W / 8;
    localparam int CW  = $clog2(FIFO_DEPTH+1);
    localparam int CW1 = CW + 1;

    state_t r_state;
    state_t w_next;

    logic [BID_W-1:0]       r_bank_id;
    logic [OFFSET_W-1:0]    r_lane;
    logic [ADDR_W-1:0]      r_bank_step;
    logic [ADDR_W-1:0]      r_bank_base;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [DDR_ADDR_W-1:0]  r_ddr_addr;
    logic [DDR_ADDR_W-1:0]  r_ddr_stride;
    logic [ALL_SIZE_W-1:0]  r_line;
    logic [ALL_SIZE_W-1:0]  r_rem;
    logic [ALL_SIZE_W-1:0]  r_rd_left;
    logic [ALL_SIZE_W-1:0]  r_wr_left;
    logic [LINE_SIZE_W-1:0] r_aw_len;
    logic [RD_LAT-1:0]      r_pipe;
    logic [CW-1:0]          r_infl;

    logic [ALL_SIZE_W-1:0]  w_eff;
    logic [ALL_SIZE_W-1:0]  w_first;
    logic [ALL_SIZE_W-1:0]  w_nlen;
    logic                   w_rd_en;
    logic                   w_ret;
    logic                   w_pop;
    logic                   w_fifo_empty;
    logic [CW-1:0]          w_cnt;
    logic [DATA_W-1:0]      w_fifo_q;
    logic                   w_take;
    logic                   w_adv;

    assign w_eff   = (cfg_line_size == '0) ? cfg_total_size
                                           : ALL_SIZE_W'(cfg_line_size);
    assign w_first = (cfg_total_size < w_eff) ? cfg_total_size : w_eff;
    assign w_nlen  = (r_rem < r_line) ? r_rem : r_line;
    assign w_ret   = r_pipe[RD_LAT-1];
    assign w_take  = (r_state == ST_IDLE) && start;
    assign w_adv   = (r_state == ST_RESP) && b_valid && (r_rem != '0);

    // Credit check counts reads still in the bank pipeline so the FIFO can't overflow.
    assign w_rd_en = (r_state == ST_DATA) && (r_rd_left != '0)
                  && ((CW1'(w_cnt) + CW1'(r_infl)) < CW1'(FIFO_DEPTH));

    assign w_valid      = (r_state == ST_DATA) && !w_fifo_empty;
    assign w_pop        = w_valid && w_ready;
    assign w_data       = w_valid ? w_fifo_q : '0;
    assign w_last       = w_valid && (r_wr_left == ALL_SIZE_W'(1));
    assign aw_valid     = (r_state == ST_CMD);
    assign aw_addr      = r_ddr_addr;
    assign aw_len       = r_aw_len;
    assign b_ready      = (r_state == ST_RESP);
    assign wr_done      = (r_state == ST_DONE);
    assign busy         = (r_state != ST_IDLE);
    assign bank_rd_en   = w_rd_en;
    assign bank_rd_id   = r_bank_id;
    assign bank_rd_addr = r_rd_addr;
    assign bank_rd_lane = r_lane;

    save_rd_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_ret),
        .i_wdata (bank_rd_data),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_q),
        .o_empty (w_fifo_empty),
        .o_count (w_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start)
                         w_next = (cfg_total_size == '0) ? ST_DONE : ST_CMD;
            ST_CMD:  if (aw_ready) w_next = ST_DATA;
            ST_DATA: if (w_pop && (r_wr_left == ALL_SIZE_W'(1)))
                         w_next = ST_RESP;
            ST_RESP: if (b_valid)
                         w_next = (r_rem == '0) ? ST_DONE : ST_CMD;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_id    <= '0;
            r_lane       <= '0;
            r_bank_step  <= '0;
            r_bank_base  <= '0;
            r_rd_addr    <= '0;
            r_ddr_addr   <= '0;
            r_ddr_stride <= '0;
            r_line       <= '0;
            r_rem        <= '0;
            r_rd_left    <= '0;
            r_wr_left    <= '0;
            r_aw_len     <= '0;
            r_pipe       <= '0;
            r_infl       <= '0;
        end else begin
            r_pipe <= RD_LAT'({r_pipe, w_rd_en});
            r_infl <= r_infl + CW'(w_rd_en) - CW'(w_ret);
            if (w_take) begin
                r_bank_id    <= cfg_bank_id;
                r_lane       <= cfg_bank_offset;
                r_bank_step  <= cfg_bank_step;
                r_bank_base  <= cfg_bank_addr;
                r_rd_addr    <= cfg_bank_addr;
                r_ddr_addr   <= cfg_ddr_addr;
                r_ddr_stride <= zero_ddr_step
                              ? DDR_ADDR_W'(w_eff) * DDR_ADDR_W'(BPW)
                              : DDR_ADDR_W'(cfg_ddr_step);
                r_line       <= w_eff;
                r_rem        <= cfg_total_size - w_first;
                r_rd_left    <= w_first;
                r_wr_left    <= w_first;
                r_aw_len     <= LINE_SIZE_W'(w_first - ALL_SIZE_W'(1));
            end
            if (w_rd_en) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
                r_rd_left <= r_rd_left - ALL_SIZE_W'(1);
            end
            if (w_pop) r_wr_left <= r_wr_left - ALL_SIZE_W'(1);
            // Next line: advance both running bases, no multiplies.
            if (w_adv) begin
                r_bank_base <= r_bank_base + r_bank_step;
                r_rd_addr   <= r_bank_base + r_bank_step;
                r_ddr_addr  <= r_ddr_addr + r_ddr_stride;
                r_rd_left   <= w_nlen;
                r_wr_left   <= w_nlen;
                r_rem       <= r_rem - w_nlen;
                r_aw_len    <= LINE_SIZE_W'(w_nlen - ALL_SIZE_W'(1));
            end
        end
    end

`ifdef SAVE_WR_RESP_CHK_EN
    logic r_wr_err;

    always_ff @(posedge clk) begin
        if (rst || w_take)
            r_wr_err <= 1'b0;
        else if (b_valid && b_ready && (b_resp != BRESP_OKAY))
            r_wr_err <= 1'b1;
    end

    assign wr_err = r_wr_err;
`else
    logic w_unused_bresp;
    assign w_unused_bresp = ^b_resp;
`endif

endmodule

// File: tb/tb_save_wr_engine.sv
// Randomized self-checking bench for save_wr_engine with a queue-based burst model.
// Bank model returns a tagged word RD_LAT cycles after each read strobe.
module tb_save_wr_engine;

    localparam int DATA_W = 128;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4;
    localparam int BPW    = DATA_W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         zero_ddr_step;
    logic [5:0]   cfg_bank_id;
    logic [11:0]  cfg_bank_addr;
    logic [11:0]  cfg_bank_step;
    logic [3:0]   cfg_bank_offset;
    logic [11:0]  cfg_line_size;
    logic [15:0]  cfg_total_size;
    logic [15:0]  cfg_ddr_step;
    logic [31:0]  cfg_ddr_addr;
    logic         bank_rd_en;
    logic [5:0]   bank_rd_id;
    logic [11:0]  bank_rd_addr;
    logic [3:0]   bank_rd_lane;
    logic [127:0] bank_rd_data;
    logic         aw_valid;
    logic         aw_ready;
    logic [31:0]  aw_addr;
    logic [11:0]  aw_len;
    logic         w_valid;
    logic         w_ready;
    logic [127:0] w_data;
    logic         w_last;
    logic         b_valid;
    logic         b_ready;
    logic [1:0]   b_resp;
    logic         busy;
    logic         wr_done;
`ifdef SAVE_WR_RESP_CHK_EN
    logic         wr_err;
`endif

    int total_n = 0;
    int bad_n   = 0;
    logic [31:0] seed = 32'h1234_5678;

    logic [31:0]  q_aw_addr [$];
    logic [11:0]  q_aw_len  [$];
    logic [11:0]  q_rd_addr [$];
    int           q_rd_line [$];
    logic [127:0] q_data    [$];
    logic         q_last    [$];

    always #5 clk = ~clk;

    save_wr_engine #(
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .zero_ddr_step   (zero_ddr_step),
        .cfg_bank_id     (cfg_bank_id),
        .cfg_bank_addr   (cfg_bank_addr),
        .cfg_bank_step   (cfg_bank_step),
        .cfg_bank_offset (cfg_bank_offset),
        .cfg_line_size   (cfg_line_size),
        .cfg_total_size  (cfg_total_size),
        .cfg_ddr_step    (cfg_ddr_step),
        .cfg_ddr_addr    (cfg_ddr_addr),
        .bank_rd_en      (bank_rd_en),
        .bank_rd_id      (bank_rd_id),
        .bank_rd_addr    (bank_rd_addr),
        .bank_rd_lane    (bank_rd_lane),
        .bank_rd_data    (bank_rd_data),
        .aw_valid        (aw_valid),
        .aw_ready        (aw_ready),
        .aw_addr         (aw_addr),
        .aw_len          (aw_len),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .w_last          (w_last),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_resp          (b_resp),
        .busy            (busy),
`ifdef SAVE_WR_RESP_CHK_EN
        .wr_err          (wr_err),
`endif
        .wr_done         (wr_done)
    );

    function automatic logic [127:0] bank_word(input logic [5:0] id,
                                               input logic [11:0] a,
                                               input logic [3:0] ln);
        return {seed ^ {26'h0, id}, 20'h0, a, 28'h0, ln, ~seed ^ {20'h0, a}};
    endfunction

    logic [127:0] bq [RD_LAT];
    always @(posedge clk) begin
        bq[0] <= bank_rd_en ? bank_word(bank_rd_id, bank_rd_addr, bank_rd_lane)
                            : {4{32'hDEAD_BEEF}};
        for (int i = 1; i < RD_LAT; i++) bq[i] <= bq[i-1];
    end
    assign bank_rd_data = bq[RD_LAT-1];

    function automatic logic outs_zero();
        return ({bank_rd_en, aw_valid, w_valid, w_last, b_ready, busy, wr_done} == 7'd0)
            && (aw_addr == 32'd0) && (aw_len == 12'd0) && (w_data == 128'd0)
            && (bank_rd_addr == 12'd0) && (bank_rd_id == 6'd0) && (bank_rd_lane == 4'd0);
    endfunction

    // Expected bursts straight from the line/total arithmetic.
    task automatic build_model(input logic zd, input logic [5:0] id,
                               input logic [11:0] ba, input logic [11:0] bs,
                               input logic [3:0] off, input logic [11:0] ls,
                               input logic [15:0] tot, input logic [15:0] ds,
                               input logic [31:0] da, output int nl);
        int eff;
        int len;
        longint stride;
        logic [11:0] a;
        q_aw_addr.delete(); q_aw_len.delete(); q_rd_addr.delete();
        q_rd_line.delete(); q_data.delete(); q_last.delete();
        nl = 0;
        if (tot == 16'd0) return;
        eff = (ls == 12'd0) ? int'(tot) : int'(ls);
        nl = (int'(tot) + eff - 1) / eff;
        stride = zd ? longint'(eff * BPW) : longint'(ds);
        for (int l = 0; l < nl; l++) begin
            len = (l == nl - 1) ? int'(tot) - (nl - 1) * eff : eff;
            q_aw_addr.push_back(32'(longint'(da) + longint'(l) * stride));
            q_aw_len.push_back(12'(len - 1));
            for (int w = 0; w < len; w++) begin
                a = 12'(int'(ba) + l * int'(bs) + w);
                q_rd_addr.push_back(a);
                q_rd_line.push_back(l);
                q_data.push_back(bank_word(id, a, off));
                q_last.push_back(w == len - 1);
            end
        end
    endtask

    task automatic run_op(input logic zd, input logic [5:0] id,
                          input logic [11:0] ba, input logic [11:0] bs,
                          input logic [3:0] off, input logic [11:0] ls,
                          input logic [15:0] tot, input logic [15:0] ds,
                          input logic [31:0] da, input int wmode,
                          input int err_line, input int restart_at,
                          input int abort_at, output int done_k,
                          output int n_aw);
        int nl, n_w, outst, max_out, aw_k, first_w, lines_b;
        int pend_b, busy_bad, aborted, ndone;
        logic [127:0] ed;
        logic el;
        seed = $urandom;
        build_model(zd, id, ba, bs, off, ls, tot, ds, da, nl);
        n_w = 0; outst = 0; max_out = 0; aw_k = -100; first_w = 0;
        lines_b = 0; pend_b = 0; busy_bad = 0; aborted = 0;
        done_k = -1; n_aw = 0;
        @(negedge clk);
        zero_ddr_step = zd; cfg_bank_id = id; cfg_bank_addr = ba;
        cfg_bank_step = bs; cfg_bank_offset = off; cfg_line_size = ls;
        cfg_total_size = tot; cfg_ddr_step = ds; cfg_ddr_addr = da;
        start = 1'b1; aw_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_resp = 2'd0;
        for (int k = 1; k <= 3000 && done_k < 0 && aborted == 0; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            if (k == restart_at) begin
                cfg_ddr_addr = $urandom;
                cfg_total_size = ~tot;
            end
`ifdef SAVE_WR_RESP_CHK_EN
            if (k == 1) begin
                total_n++;
                if (wr_err !== 1'b0) begin
                    bad_n++;
                    $display("FAIL wr_err_clear: got %b want 0", wr_err);
                end
            end
`endif
            if (abort_at > 0 && n_w == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                total_n++;
                if (!outs_zero()) begin
                    bad_n++;
                    $display("FAIL abort_outs: busy=%b aw_v=%b w_v=%b rd_en=%b want all 0",
                             busy, aw_valid, w_valid, bank_rd_en);
                end
                ndone = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (wr_done) ndone++;
                end
                total_n++;
                if (ndone != 0 || busy !== 1'b0) begin
                    bad_n++;
                    $display("FAIL abort_quiet: done=%0d busy=%b want 0 0", ndone, busy);
                end
                aborted = 1;
            end else begin
                if (!busy) busy_bad++;
                aw_ready = (wmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
                w_ready  = (wmode == 0) ? 1'b1 :
                           (wmode == 1) ? (k % 3 == 0) : ($urandom_range(0, 1) == 1);
                b_valid  = (pend_b != 0) && (wmode == 0 || $urandom_range(0, 1) == 1);
                b_resp   = (b_valid && lines_b == err_line) ? 2'd2 : 2'd0;
                if (bank_rd_en) begin
                    total_n++;
                    if (q_rd_addr.size() == 0) begin
                        bad_n++;
                        $display("FAIL rd_extra: got addr %h want none", bank_rd_addr);
                    end else begin
                        if (bank_rd_addr !== q_rd_addr[0] || bank_rd_id !== id ||
                            bank_rd_lane !== off || q_rd_line[0] >= n_aw) begin
                            bad_n++;
                            $display("FAIL rd_req: got %h/%h/%h aw_done=%0d want %h/%h/%h line %0d",
                                     bank_rd_addr, bank_rd_id, bank_rd_lane, n_aw,
                                     q_rd_addr[0], id, off, q_rd_line[0]);
                        end
                        void'(q_rd_addr.pop_front());
                        void'(q_rd_line.pop_front());
                    end
                    outst++;
                    if (outst > max_out) max_out = outst;
                end
                if (w_valid && first_w != 0) begin
                    total_n++;
                    if (k - aw_k < RD_LAT + 1) begin
                        bad_n++;
                        $display("FAIL w_latency: got %0d want >= %0d", k - aw_k, RD_LAT + 1);
                    end
                    first_w = 0;
                end
                if (w_valid && w_ready) begin
                    total_n++;
                    if (q_data.size() == 0) begin
                        bad_n++;
                        $display("FAIL w_extra: got %h want none", w_data);
                    end else begin
                        ed = q_data.pop_front();
                        el = q_last.pop_front();
                        if (w_data !== ed || w_last !== el) begin
                            bad_n++;
                            $display("FAIL w_beat %0d: got %h last %b want %h last %b",
                                     n_w, w_data, w_last, ed, el);
                        end
                    end
                    n_w++;
                    outst--;
                    if (w_last) pend_b = 1;
                end
                if (aw_valid && aw_ready) begin
                    total_n++;
                    if (q_aw_addr.size() == 0) begin
                        bad_n++;
                        $display("FAIL aw_extra: got %h want none", aw_addr);
                    end else begin
                        if (aw_addr !== q_aw_addr[0] || aw_len !== q_aw_len[0]) begin
                            bad_n++;
                            $display("FAIL aw_cmd %0d: got %h len %0d want %h len %0d",
                                     n_aw, aw_addr, aw_len, q_aw_addr[0], q_aw_len[0]);
                        end
                        void'(q_aw_addr.pop_front());
                        void'(q_aw_len.pop_front());
                    end
                    n_aw++;
                    aw_k = k;
                    first_w = 1;
                end
                if (b_valid && b_ready) begin
                    lines_b++;
                    pend_b = 0;
                end
                if (wr_done) done_k = k;
            end
        end
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'd0;
        start = 1'b0;
        if (aborted != 0) return;
        total_n++;
        if (done_k < 0) begin
            bad_n++;
            $display("FAIL timeout: got no wr_done want one within 3000 cycles");
            return;
        end
        @(negedge clk);
        total_n++;
        if (wr_done !== 1'b0 || busy !== 1'b0) begin
            bad_n++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", wr_done, busy);
        end
        total_n++;
        if (n_aw != nl || lines_b != nl || q_data.size() != 0 ||
            q_rd_addr.size() != 0 || busy_bad != 0) begin
            bad_n++;
            $display("FAIL op_totals: got aw=%0d b=%0d left=%0d/%0d busy_bad=%0d want %0d %0d 0/0 0",
                     n_aw, lines_b, q_data.size(), q_rd_addr.size(), busy_bad, nl, nl);
        end
        total_n++;
        if (max_out > DEPTH) begin
            bad_n++;
            $display("FAIL fifo_credit: got %0d outstanding want <= %0d", max_out, DEPTH);
        end
`ifdef SAVE_WR_RESP_CHK_EN
        total_n++;
        if (wr_err !== (err_line >= 0 && err_line < nl)) begin
            bad_n++;
            $display("FAIL wr_err: got %b want %b", wr_err, (err_line >= 0 && err_line < nl));
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; zero_ddr_step = 1'b0;
        cfg_bank_id = '0; cfg_bank_addr = '0; cfg_bank_step = '0;
        cfg_bank_offset = '0; cfg_line_size = '0; cfg_total_size = '0;
        cfg_ddr_step = '0; cfg_ddr_addr = '0;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'd0;
        repeat (3) @(negedge clk);
        total_n++;
        if (!outs_zero()) begin
            bad_n++;
            $display("FAIL reset_outs: busy=%b aw_v=%b w_v=%b done=%b want all 0",
                     busy, aw_valid, w_valid, wr_done);
        end
        rst = 1'b0;
        @(negedge clk);
        total_n++;
        if (busy !== 1'b0 || wr_done !== 1'b0) begin
            bad_n++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0", busy, wr_done);
        end
    endtask

    task automatic test_basic();
        int dk, na;
        run_op(1'b0, 6'd5, 12'h010, 12'h100, 4'd3, 12'd4, 16'd8, 16'h400,
               32'h1000, 0, -1, -1, 0, dk, na);
        total_n++;
        if (na != 2) begin
            bad_n++;
            $display("FAIL basic_bursts: got %0d want 2", na);
        end
    endtask

    task automatic test_contig();
        int dk, na;
        run_op(1'b1, 6'd9, 12'h200, 12'h040, 4'd1, 12'd4, 16'd10, 16'h0,
               32'h0000_2000, 2, -1, -1, 0, dk, na);
        total_n++;
        if (na != 3) begin
            bad_n++;
            $display("FAIL contig_bursts: got %0d want 3", na);
        end
    endtask

    task automatic test_backpressure();
        int dk, na;
        run_op(1'b0, 6'd17, 12'h300, 12'h020, 4'd7, 12'd8, 16'd24, 16'h200,
               32'h8000_0000, 1, -1, -1, 0, dk, na);
        total_n++;
        if (na != 3) begin
            bad_n++;
            $display("FAIL bp_bursts: got %0d want 3", na);
        end
    endtask

    task automatic test_edge_sizes();
        int dk, na;
        // start sampled on one edge, wr_done present in the very next cycle
        run_op(1'b0, 6'd1, 12'h0, 12'h0, 4'd0, 12'd4, 16'd0, 16'h0,
               32'h100, 0, -1, -1, 0, dk, na);
        total_n++;
        if (dk != 1 || na != 0) begin
            bad_n++;
            $display("FAIL zero_total: got done_k=%0d aw=%0d want 1 0", dk, na);
        end
        run_op(1'b0, 6'd2, 12'hFFE, 12'h0, 4'd2, 12'd0, 16'd5, 16'h0,
               32'hFFFF_FFF0, 2, -1, -1, 0, dk, na);
        total_n++;
        if (na != 1) begin
            bad_n++;
            $display("FAIL line0_bursts: got %0d want 1", na);
        end
    endtask

    task automatic test_busy_and_reset();
        int dk, na;
        run_op(1'b0, 6'd33, 12'h080, 12'h010, 4'd5, 12'd8, 16'd32, 16'h100,
               32'h4000, 2, -1, 3, 3, dk, na);
        total_n++;
        if (dk != -1) begin
            bad_n++;
            $display("FAIL abort_no_done: got done_k=%0d want -1", dk);
        end
        run_op(1'b0, 6'd4, 12'h500, 12'h008, 4'd6, 12'd4, 16'd6, 16'h080,
               32'h5000, 0, -1, 2, 0, dk, na);
        total_n++;
        if (na != 2) begin
            bad_n++;
            $display("FAIL restart_ignored: got %0d bursts want 2", na);
        end
    endtask

    task automatic test_random();
        int dk, na, exp_nl, eff;
        logic [15:0] tot;
        logic [11:0] ls;
        for (int it = 0; it < 10; it++) begin
            tot = 16'($urandom_range(0, 40));
            ls  = 12'($urandom_range(0, 15));
            run_op(1'($urandom), 6'($urandom), 12'($urandom), 12'($urandom),
                   4'($urandom), ls, tot, 16'($urandom), $urandom,
                   $urandom_range(0, 2), -1, -1, 0, dk, na);
            eff = (ls == 12'd0) ? int'(tot) : int'(ls);
            exp_nl = (tot == 16'd0) ? 0 : (int'(tot) + eff - 1) / eff;
            total_n++;
            if (na != exp_nl) begin
                bad_n++;
                $display("FAIL rand_bursts %0d: got %0d want %0d", it, na, exp_nl);
            end
        end
    endtask

`ifdef SAVE_WR_RESP_CHK_EN
    task automatic test_resp_err();
        int dk, na;
        run_op(1'b0, 6'd8, 12'h010, 12'h100, 4'd0, 12'd4, 16'd8, 16'h400,
               32'h1000, 0, 1, -1, 0, dk, na);
        total_n++;
        if (dk < 0) begin
            bad_n++;
            $display("FAIL err_done: got no wr_done want pulse");
        end
        run_op(1'b0, 6'd8, 12'h020, 12'h100, 4'd0, 12'd4, 16'd4, 16'h400,
               32'h3000, 2, -1, -1, 0, dk, na);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_contig();
        test_backpressure();
        test_edge_sizes();
        test_busy_and_reset();
        test_random();
`ifdef SAVE_WR_RESP_CHK_EN
        test_resp_err();
`endif
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
